// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one repeated-addition multiplier among NUM_REQ requesters.
// Optional feature: define MUL_ZERO_BYPASS_EN to short-circuit jobs with a zero operand.
module mul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         dp_a,
    output logic [DW-1:0]         dp_b,
    output logic                  dp_lda,
    output logic                  dp_ldb,
    output logic                  dp_ldp,
    output logic                  dp_clrp,
    output logic                  dp_decb,
    input  logic                  dp_done,
    input  logic [DW-1:0]         dp_product,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LOAD, ACCUM, RESP} state_t;

    state_t         state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic            any;
    logic            grant;
    logic [DW-1:0]   a_arr [NUM_REQ];
    logic [DW-1:0]   b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DW +: DW];
        assign b_arr[g] = req_b[g*DW +: DW];
    end

    // Scan offsets downward so the smallest offset from rr_ptr wins last.
    always_comb begin
        logic [ID_W:0]   s;
        logic [ID_W-1:0] idx;
        any = 1'b0;
        win = '0;
        s   = '0;
        idx = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            s = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
            idx = s[ID_W-1:0];
            if (req_valid[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

    assign grant = (state == IDLE) && any;

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_now, zero_q;
    assign zero_now = (a_arr[win] == '0) || (b_arr[win] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        zero_q <= 1'b0;
        else if (grant) zero_q <= zero_now;
    end

    assign rsp_data = (state == RESP && zero_q) ? '0 : dp_product;
`else
    assign rsp_data = dp_product;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            dp_a   <= '0;
            dp_b   <= '0;
            rsp_id <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                dp_a   <= a_arr[win];
                dp_b   <= b_arr[win];
                rsp_id <= win;
                rr_ptr <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        dp_lda    = 1'b0;
        dp_ldb    = 1'b0;
        dp_ldp    = 1'b0;
        dp_clrp   = 1'b0;
        dp_decb   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                dp_clrp = 1'b1;
                if (any) begin
                    req_ready[win] = 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
                    state_nxt = zero_now ? RESP : LOAD;
`else
                    state_nxt = LOAD;
`endif
                end
            end
            LOAD: begin
                dp_lda    = 1'b1;
                dp_ldb    = 1'b1;
                dp_clrp   = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                dp_ldp  = !dp_done;
                dp_decb = !dp_done;
                if (dp_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural repeated-addition datapath.
module tb_mul_share_ctrl;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_a = '0;
    logic [NR*DW-1:0] req_b = '0;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    dp_a, dp_b;
    logic dp_lda, dp_ldb, dp_ldp, dp_clrp, dp_decb, dp_done;
    logic [DW-1:0]    dp_product;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [1:0]       rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    mul_share_ctrl #(.NUM_REQ(NR), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_lda(dp_lda), .dp_ldb(dp_ldb),
        .dp_ldp(dp_ldp), .dp_clrp(dp_clrp), .dp_decb(dp_decb), .dp_done(dp_done),
        .dp_product(dp_product), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath model: A/B/P registers, no reset.
    logic [DW-1:0] ra = '0, rb = '0, rp = '0;
    always @(posedge clk) begin
        if (dp_lda) ra <= dp_a;
        if (dp_ldb) rb <= dp_b;
        else if (dp_decb) rb <= rb - 8'd1;
        if (dp_clrp) rp <= '0;
        else if (dp_ldp) rp <= rp + ra;
    end
    assign dp_done    = (rb == '0);
    assign dp_product = rp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = a;
            req_b[i*DW +: DW] = b;
        end
    endtask

    // Issue one job with rsp_ready=1 and check grant, latency, result and accumulate count.
    task automatic run_job(input string tag, input logic [NR-1:0] mask, input bit keep,
                           input logic [NR-1:0] exp_rdy, input int exp_id, input int exp_lat,
                           input int exp_data, input int exp_ldp);
        int lat, ldp;
        req_valid = mask;
        #1;
        chk({tag, " ready"}, 32'(req_ready), 32'(exp_rdy));
        chk({tag, " idle"}, 32'(busy), 32'd0);
        step();
        if (!keep) req_valid = '0;
        lat = 1;
        ldp = 0;
        while (!rsp_valid && lat < 100) begin
            if (dp_ldp) ldp++;
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, " id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, " ldp cycles"}, 32'(ldp), 32'(exp_ldp));
        step();
        chk({tag, " back idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int zl;
        bit stable;
        bit seen;
`ifdef MUL_ZERO_BYPASS_EN
        zl = 1;
`else
        zl = 3;
`endif
        // Reset state
        do_reset();
        chk("rst clrp", 32'(dp_clrp), 32'd1);
        chk("rst strobes", 32'({dp_lda, dp_ldb, dp_ldp, dp_decb}), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst dp_a", 32'(dp_a), 32'd0);

        // 1: single job 5*3
        set_ops(8'd5, 8'd3);
        run_job("t1", 4'b0001, 1'b0, 4'b0001, 0, 6, 15, 3);
        chk("t1 dp_a", 32'(dp_a), 32'd5);

        // 2: round robin from reset with all valid held
        do_reset();
        chk("t2 rst dp_a", 32'(dp_a), 32'd0);
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = 8'(i + 1);
            req_b[i*DW +: DW] = 8'd2;
        end
        run_job("t2 j0", 4'b1111, 1'b1, 4'b0001, 0, 5, 2, 2);
        run_job("t2 j1", 4'b1111, 1'b1, 4'b0010, 1, 5, 4, 2);
        run_job("t2 j2", 4'b1111, 1'b1, 4'b0100, 2, 5, 6, 2);
        run_job("t2 j3", 4'b1111, 1'b1, 4'b1000, 3, 5, 8, 2);
        run_job("t2 j4", 4'b1111, 1'b0, 4'b0001, 0, 5, 2, 2);

        // 3: backpressure on req1 (6*2) while req2 waits
        rsp_ready = 1'b0;
        set_ops(8'd6, 8'd2);
        req_valid = 4'b0010;
        #1;
        chk("t3 ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        zl = (zl == 1) ? 1 : 3;
        for (int n = 0; n < 30 && !rsp_valid; n++) step();
        chk("t3 data", 32'(rsp_data), 32'd12);
        chk("t3 id", 32'(rsp_id), 32'd1);
        set_ops(8'd20, 8'd15);
        req_valid = 4'b0100;
        stable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (!rsp_valid || rsp_data != 8'd12 || rsp_id != 2'd1 || req_ready != '0 || !busy)
                stable = 1'b0;
        end
        chk("t3 stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        step();
        chk("t3 post busy", 32'(busy), 32'd0);
        chk("t3 post rsp", 32'(rsp_valid), 32'd0);

        // 4: wrap 20*15=300 -> 44, then zero operand
        run_job("t4 wrap", 4'b0100, 1'b0, 4'b0100, 2, 18, 44, 15);
        set_ops(8'd7, 8'd0);
        run_job("t4 zero", 4'b1000, 1'b0, 4'b1000, 3, zl, 0, 0);

        // 5: reset in the middle of ACCUM
        set_ops(8'd9, 8'd10);
        req_valid = 4'b0010;
        #1;
        chk("t5 ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        step();
        step();
        chk("t5 accum busy", 32'(busy), 32'd1);
        chk("t5 accum ldp", 32'(dp_ldp), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst clrp", 32'(dp_clrp), 32'd1);
        chk("t5 rst ldp", 32'(dp_ldp), 32'd0);
        chk("t5 rst rsp_id", 32'(rsp_id), 32'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            step();
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("t5 no rsp", 32'(seen), 32'd0);
        set_ops(8'd3, 8'd4);
        run_job("t5 job", 4'b1111, 1'b0, 4'b0001, 0, 7, 12, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
